// File: rtl/spi_cmd_pkg.sv
// Shared op codes, frame widths and FSM state encoding for the SPI command master.
package spi_cmd_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'd0;
    localparam logic [1:0] OP_WR_DATA = 2'd1;
    localparam logic [1:0] OP_RD_ADDR = 2'd2;
    localparam logic [1:0] OP_RD_DATA = 2'd3;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_CMD,
        TURN,
        SHIFT_RD,
        HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: CLK_DIV clk cycles per half-period, starting low after clear.
// rise_stb_o/fall_stb_o flag the cycle whose closing edge moves sclk_o.
module spi_sclk_gen
    import spi_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       last;

    assign last = (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (last) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = en_i & last & ~sclk_q;
    assign fall_stb_o = en_i & last & sclk_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for 10-bit {op,data} frames with 8-bit read-back on op 3.
// Optional: SPI_CMD_MASTER_AUTO_READ_EN chains an op-3 frame after every op-2 frame.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       sclk,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned GAP_CYC = 2 * CLK_DIV * IDLE_GAP;

    state_e              state_q;
    logic [FRAME_W-1:0]  shift_q;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [3:0]          cnt_q;
    logic [12:0]         gap_q;
    logic [1:0]          op_q;
    logic                ss_n_q, mosi_q, cmd_ready_q, busy_q, rsp_valid_q;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
    logic                auto_q;
`endif

    logic gen_en, gen_clr, rise_stb, fall_stb;

    // HOLD ends on the would-be rising strobe; clearing there keeps sclk low.
    assign gen_en  = (state_q != IDLE) && (state_q != GAP);
    assign gen_clr = (state_q == IDLE) || (state_q == GAP) || ((state_q == HOLD) && rise_stb);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (gen_en),
        .clr_i     (gen_clr),
        .sclk_o    (sclk),
        .rise_stb_o(rise_stb),
        .fall_stb_o(fall_stb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            rd_q        <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            op_q        <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
            auto_q      <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        shift_q     <= {cmd_op, cmd_data};
                        op_q        <= cmd_op;
                        mosi_q      <= cmd_op[1];
                        ss_n_q      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
                        auto_q      <= (cmd_op == OP_RD_ADDR);
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (rise_stb) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT_CMD;
                    end
                end
                SHIFT_CMD: begin
                    if (fall_stb) begin
                        shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
                        mosi_q  <= shift_q[FRAME_W-2];
                        if (cnt_q == 4'(FRAME_W - 1)) begin
                            cnt_q <= '0;
                            if (op_q == OP_RD_DATA)
                                state_q <= (TURNAROUND == 0) ? SHIFT_RD : TURN;
                            else
                                state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                TURN: begin
                    if (fall_stb) begin
                        if (cnt_q == 4'(TURNAROUND - 1)) begin
                            cnt_q   <= '0;
                            state_q <= SHIFT_RD;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                SHIFT_RD: begin
                    if (rise_stb)
                        rd_q <= {rd_q[DATA_W-2:0], miso};
                    if (fall_stb) begin
                        if (cnt_q == 4'(DATA_W - 1)) begin
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (rise_stb) begin
                        ss_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        gap_q   <= 13'(GAP_CYC - 1);
                        state_q <= GAP;
                        if (op_q == OP_RD_DATA) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_q;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
                        if (auto_q) begin
                            // Chained read frame: cmd_ready stays low throughout.
                            auto_q  <= 1'b0;
                            shift_q <= {OP_RD_DATA, 8'h00};
                            op_q    <= OP_RD_DATA;
                            mosi_q  <= OP_RD_DATA[1];
                            ss_n_q  <= 1'b0;
                            state_q <= SETUP;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
`else
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`endif
                    end else begin
                        gap_q <= gap_q - 13'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: two instances (CLK_DIV=2/TA=1 and CLK_DIV=1/TA=0),
// a mode-0 slave/monitor per instance, a vector table plus reset, back-to-back and auto-read sequences.
module tb_spi_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       valid_v [2];
    logic [1:0] op_v    [2];
    logic [7:0] data_v  [2];
    logic       miso_v  [2];
    logic       ready_o [2];
    logic       rspv_o  [2];
    logic [7:0] rspd_o  [2];
    logic       busy_o  [2];
    logic       sclk_o  [2];
    logic       ssn_o   [2];
    logic       mosi_o  [2];

    spi_cmd_master #(.CLK_DIV(2), .TURNAROUND(1), .IDLE_GAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_v[0]), .cmd_valid(valid_v[0]), .cmd_ready(ready_o[0]),
        .cmd_op(op_v[0]), .cmd_data(data_v[0]), .rsp_valid(rspv_o[0]), .rsp_data(rspd_o[0]),
        .busy(busy_o[0]), .sclk(sclk_o[0]), .ss_n(ssn_o[0]), .mosi(mosi_o[0]), .miso(miso_v[0])
    );

    spi_cmd_master #(.CLK_DIV(1), .TURNAROUND(0), .IDLE_GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_v[1]), .cmd_valid(valid_v[1]), .cmd_ready(ready_o[1]),
        .cmd_op(op_v[1]), .cmd_data(data_v[1]), .rsp_valid(rspv_o[1]), .rsp_data(rspd_o[1]),
        .busy(busy_o[1]), .sclk(sclk_o[1]), .ss_n(ssn_o[1]), .mosi(mosi_o[1]), .miso(miso_v[1])
    );

    // Slave model and frame monitor state, one slot per instance.
    logic [7:0] rd_byte   [2];
    logic [9:0] mosi_cap  [2];
    logic       ss_prev   [2] = '{1'b1, 1'b1};
    logic       sclk_prev [2] = '{1'b0, 1'b0};
    int cyc [2] = '{0, 0};
    int low_cnt [2] = '{0, 0};
    int last_low [2] = '{0, 0};
    int prev_low [2] = '{0, 0};
    int frames [2] = '{0, 0};
    int rises [2] = '{0, 0};
    int falls [2] = '{0, 0};
    int rsp_cnt [2] = '{0, 0};
    int rsp_rise [2] = '{0, 0};
    int acc_cnt [2] = '{0, 0};
    int acc_delta [2] = '{0, 0};
    int rise_cyc [2] = '{0, 0};
    int rdy_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int k;
            int ta;
            ta = (g == 0) ? 1 : 0;
            cyc[g]++;
            if (!rst_v[g]) miso_v[g] = 1'b0;
            if (ready_o[g]) rdy_cnt[g]++;
            if (ready_o[g] && valid_v[g]) begin
                acc_cnt[g]++;
                acc_delta[g] = cyc[g] - rise_cyc[g];
            end
            if (ss_prev[g] && !ssn_o[g]) begin
                rises[g] = 0; falls[g] = 0; low_cnt[g] = 0; mosi_cap[g] = '0;
            end
            if (!ssn_o[g]) low_cnt[g]++;
            if (!ss_prev[g] && ssn_o[g]) begin
                prev_low[g] = last_low[g];
                last_low[g] = low_cnt[g];
                frames[g]++;
                rise_cyc[g] = cyc[g];
                miso_v[g] = 1'b0;
                if (rspv_o[g]) rsp_rise[g]++;
            end
            if (rspv_o[g]) rsp_cnt[g]++;
            if (!ssn_o[g] && !sclk_prev[g] && sclk_o[g]) begin
                rises[g]++;
                if (rises[g] <= 10) mosi_cap[g] = {mosi_cap[g][8:0], mosi_o[g]};
            end
            if (!ssn_o[g] && sclk_prev[g] && !sclk_o[g]) begin
                falls[g]++;
                k = falls[g] - 10 - ta;
                if (k >= 0 && k < 8) miso_v[g] = rd_byte[g][7-k];
            end
            ss_prev[g]   = ssn_o[g];
            sclk_prev[g] = sclk_o[g];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int g, input logic [1:0] op, input logic [7:0] d);
        int t;
        t = 0;
        op_v[g] = op; data_v[g] = d; valid_v[g] = 1'b1;
        while (!ready_o[g] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("accept_timeout", t, 0);
        @(negedge clk);
        valid_v[g] = 1'b0;
    endtask

    task automatic wait_frames(input int g, input int target);
        int t;
        t = 0;
        while (frames[g] < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done", int'(frames[g] >= target), 1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int         g;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] miso;
        int         low;
        int         rises;
        logic [9:0] mosi;
        int         rsp;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int b_fr, b_rsp, b_rr, b_acc, r0;

        vecs[0] = '{0, 2'd0, 8'h3C, 8'h00, 42, 10, 10'h03C, 0, 8'h00};
        vecs[1] = '{0, 2'd3, 8'h00, 8'hA5, 78, 19, 10'h300, 1, 8'hA5};
        vecs[2] = '{0, 2'd1, 8'hC3, 8'h00, 42, 10, 10'h1C3, 0, 8'hA5};
        vecs[3] = '{0, 2'd3, 8'h81, 8'h3C, 78, 19, 10'h381, 1, 8'h3C};
        vecs[4] = '{1, 2'd3, 8'h00, 8'hFF, 37, 18, 10'h300, 1, 8'hFF};
        vecs[5] = '{1, 2'd3, 8'h00, 8'h00, 37, 18, 10'h300, 1, 8'h00};
        vecs[6] = '{1, 2'd0, 8'hAA, 8'h55, 21, 10, 10'h0AA, 0, 8'h00};

        for (int g = 0; g < 2; g++) begin
            rst_v[g] = 1'b0; valid_v[g] = 1'b0; op_v[g] = '0; data_v[g] = '0; rd_byte[g] = '0;
        end
        repeat (3) @(negedge clk);

        for (int g = 0; g < 2; g++) begin
            chk("rst_ss_n", int'(ssn_o[g]), 1);
            chk("rst_sclk", int'(sclk_o[g]), 0);
            chk("rst_mosi", int'(mosi_o[g]), 0);
            chk("rst_cmd_ready", int'(ready_o[g]), 0);
            chk("rst_busy", int'(busy_o[g]), 0);
            chk("rst_rsp_valid", int'(rspv_o[g]), 0);
            chk("rst_rsp_data", int'(rspd_o[g]), 0);
        end
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", int'(ready_o[0]), 1);
        chk("post_rst_ready1", int'(ready_o[1]), 1);

        for (int i = 0; i < 7; i++) begin
            int g;
            g = vecs[i].g;
            rd_byte[g] = vecs[i].miso;
            b_fr = frames[g]; b_rsp = rsp_cnt[g]; b_rr = rsp_rise[g];
            send(g, vecs[i].op, vecs[i].data);
            wait_frames(g, b_fr + 1);
            chk($sformatf("v%0d_ss_low", i), last_low[g], vecs[i].low);
            chk($sformatf("v%0d_rises", i), rises[g], vecs[i].rises);
            chk($sformatf("v%0d_mosi", i), int'(mosi_cap[g]), int'(vecs[i].mosi));
            chk($sformatf("v%0d_rsp_count", i), rsp_cnt[g] - b_rsp, vecs[i].rsp);
            chk($sformatf("v%0d_rsp_at_ss_rise", i), rsp_rise[g] - b_rr, vecs[i].rsp);
            chk($sformatf("v%0d_rsp_data", i), int'(rspd_o[g]), int'(vecs[i].rd));
        end

        // Back-to-back with cmd_valid held, then a request while busy.
        b_fr = frames[0]; b_acc = acc_cnt[0];
        op_v[0] = 2'd0; data_v[0] = 8'h55; valid_v[0] = 1'b1;
        for (int t = 0; t < 1000 && acc_cnt[0] < b_acc + 2; t++) @(negedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        op_v[0] = 2'd1; valid_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        valid_v[0] = 1'b0;
        wait_frames(0, b_fr + 2);
        repeat (60) @(negedge clk);
        chk("b2b_accept_delay", acc_delta[0], 4);
        chk("b2b_accepts", acc_cnt[0] - b_acc, 2);
        chk("b2b_frames", frames[0] - b_fr, 2);
        chk("b2b_first_low", prev_low[0], 42);
        chk("b2b_second_low", last_low[0], 42);
        chk("b2b_idle_ready", int'(ready_o[0]), 1);

        // Reset at the 5th sclk rise of an op-3 frame.
        rd_byte[0] = 8'hC3;
        b_rsp = rsp_cnt[0];
        send(0, 2'd3, 8'hFF);
        for (int t = 0; t < 500 && rises[0] < 5; t++) @(negedge clk);
        chk("abort_pre_ss_n", int'(ssn_o[0]), 0);
        chk("abort_pre_mosi", int'(mosi_o[0]), 1);
        rst_v[0] = 1'b0;
        @(negedge clk);
        rst_v[0] = 1'b1;
        chk("abort_ss_n", int'(ssn_o[0]), 1);
        chk("abort_sclk", int'(sclk_o[0]), 0);
        chk("abort_mosi", int'(mosi_o[0]), 0);
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_rsp_data", int'(rspd_o[0]), 0);
        @(negedge clk);
        chk("abort_ready", int'(ready_o[0]), 1);
        chk("abort_ss_n_after", int'(ssn_o[0]), 1);
        chk("abort_busy_after", int'(busy_o[0]), 0);
        repeat (100) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt[0] - b_rsp, 0);

        // Op 2: chained read when auto-read is built in, plain frame otherwise.
        rd_byte[0] = 8'h7E;
        b_fr = frames[0]; b_rsp = rsp_cnt[0]; b_rr = rsp_rise[0];
        send(0, 2'd2, 8'h10);
        r0 = rdy_cnt[0];
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
        wait_frames(0, b_fr + 2);
        chk("auto_first_low", prev_low[0], 42);
        chk("auto_second_low", last_low[0], 78);
        chk("auto_second_mosi", int'(mosi_cap[0]), 10'h300);
        chk("auto_rsp_count", rsp_cnt[0] - b_rsp, 1);
        chk("auto_rsp_at_ss_rise", rsp_rise[0] - b_rr, 1);
        chk("auto_rsp_data", int'(rspd_o[0]), 8'h7E);
        chk("auto_no_ready_between", rdy_cnt[0] - r0, 0);
`else
        wait_frames(0, b_fr + 1);
        chk("op2_no_ready_in_frame", rdy_cnt[0] - r0, 0);
        repeat (80) @(negedge clk);
        chk("op2_frames", frames[0] - b_fr, 1);
        chk("op2_low", last_low[0], 42);
        chk("op2_mosi", int'(mosi_cap[0]), 10'h210);
        chk("op2_rsp_count", rsp_cnt[0] - b_rsp, 0);
        chk("op2_rsp_data", int'(rspd_o[0]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1);
    end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI initiator that drives the 10-bit command frames consumed by the team's SPI slave and RAM path.
- Frame format is {op[1:0], data[7:0]}, with op 0 = write address, 1 = write data, 2 = read address, 3 = read data.
- Accepts one command per valid/ready handshake from a local controller, serialises it onto MOSI, and for op 3 clocks 8 read-data bits back from MISO.
- Sits on the host side of the board-level SPI link (bench driver or host SoC bridge).

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range 1..255.
- TURNAROUND, 1: idle SCLK periods between command bit 0 and the first read-data bit in op-3 frames; legal range 0..15.
- IDLE_GAP, 1: minimum full SCLK periods with ss_n high between frames; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_op  in  2  frame op bits [9:8].
- cmd_data  in  8  frame bits [7:0] (address or write data).
- rsp_valid  out  1  single-cycle pulse: read data available.
- rsp_data  out  8  last read byte.
- busy  out  1  frame in progress, or the idle gap is running.
- sclk  out  1  SPI clock, mode 0 (idle low).
- ss_n  out  1  slave select, active low.
- mosi  out  1  serial command, MSB first.
- miso  in  1  serial read data, MSB first.

Behaviour:
- Reset, synchronous on clk when rst_n=0: all outputs take these values.
  - ss_n=1, sclk=0, mosi=0, cmd_ready=0 during reset and 1 from the first cycle after.
  - rsp_valid=0, rsp_data=0, busy=0.
  - State machine returns to IDLE and the divider is cleared.
- Reset mid-frame aborts the frame immediately. No rsp_valid is produced.
- Handshake:
  - A command is accepted on a cycle where cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE.
  - cmd_valid while not ready is ignored, not queued.
- States:
  - IDLE -> SETUP on accept. In the same accept cycle: capture {op,data} into shift_reg[9:0], drive ss_n=0, drive mosi=shift_reg[9].
  - SETUP: CLK_DIV cycles, sclk low -> SHIFT_CMD.
  - SHIFT_CMD: 10 SCLK periods. sclk goes high for CLK_DIV cycles, then low for CLK_DIV cycles. The slave samples on the rising edge. mosi advances to the next bit on each falling edge.
  - After the 10th falling edge: op 3 -> TURN (or directly to SHIFT_RD if TURNAROUND=0); otherwise -> HOLD.
  - TURN: TURNAROUND periods, sclk keeps toggling, mosi=0, MISO ignored.
  - SHIFT_RD: 8 SCLK periods. miso is sampled into rd_shift on each rising-edge strobe, MSB first. mosi=0.
  - HOLD: CLK_DIV cycles with sclk low. Then ss_n=1 and go to GAP.
  - GAP: 2*CLK_DIV*IDLE_GAP cycles -> IDLE.
- Timing with T = accept cycle: ss_n is low from T to T+(2N+1)*CLK_DIV-1.
  - N = 10 for ops 0/1/2.
  - N = 18+TURNAROUND for op 3.
- Read response: rsp_data is loaded from rd_shift in the cycle ss_n rises, and rsp_valid pulses in that same cycle. rsp_data holds until the next op-3 completion.
- busy=1 in every state except IDLE.
- No back-pressure on rsp_valid: a missed pulse is lost, and rsp_data stays readable.

Optional Feature:
- Macro SPI_CMD_MASTER_AUTO_READ_EN.
- Defined:
  - An accepted op-2 command, after its GAP, automatically launches an op-3 frame with data=8'h00, without cmd_ready rising in between.
  - Only the op-3 frame produces rsp_valid.
  - A reset during the auto frame aborts both frames.
- Undefined: op 2 is a plain 10-bit frame and the auto-read logic is absent.

Decomposition:
- Package spi_cmd_pkg holds:
  - Op constants OP_WR_ADDR=2'd0, OP_WR_DATA=2'd1, OP_RD_ADDR=2'd2, OP_RD_DATA=2'd3.
  - FRAME_W=10, DATA_W=8.
  - State enum IDLE/SETUP/SHIFT_CMD/TURN/SHIFT_RD/HOLD/GAP.
- Sub-module spi_sclk_gen contains the CLK_DIV counter. It produces sclk plus single-cycle rise_stb and fall_stb strobes, and has an enable and a synchronous clear.

Test Plan:
1. CLK_DIV=2: op 0, data 8'h3C.
   - mosi on rising edges = 00_0011_1100.
   - ss_n low exactly 42 cycles, exactly 10 sclk rises, no rsp_valid.
2. Op 3, TURNAROUND=1, slave model drives miso with 8'hA5.
   - ss_n low 78 cycles; rsp_valid pulses once as ss_n rises; rsp_data=8'hA5.
3. Back-to-back commands with cmd_valid held high.
   - Second accept occurs exactly 4 cycles (IDLE_GAP=1) after ss_n rises.
   - cmd_valid during busy is ignored.
4. rst_n=0 for 1 cycle at the 5th sclk rise of an op-3 frame.
   - Next cycle: ss_n=1, sclk=0, mosi=0, cmd_ready=1, busy=0, rsp_valid never asserted.
5. With SPI_CMD_MASTER_AUTO_READ_EN: op 2, data 8'h10, miso model returns 8'h7E.
   - Two ss_n low windows: 42 then 78 cycles; single rsp_valid with rsp_data=8'h7E.
   - Without the macro: a single 42-cycle frame.
6. CLK_DIV=1, TURNAROUND=0, op 3, miso=8'hFF then 8'h00.
   - Sequential rsp_data values 8'hFF and 8'h00; ss_n low 37 cycles each.
